// File: rtl/chip_data_pkg.sv
// chip_data_pkg: shared geometry and FSM state type for the chip bit-plane store sequencer.
package chip_data_pkg;
    localparam int BLK      = 100;
    localparam int NCHIP    = 4;
    localparam int NBANK    = 2;
    localparam int WR_TOTAL = NCHIP * NBANK * BLK;
    localparam int RD_TOTAL = NBANK * BLK;
    localparam int WR_AW    = 10;
    localparam int RD_AW    = 9;
    typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} seq_state_t;
endpackage

// File: rtl/out_fifo2.sv
// out_fifo2: 2-entry, 4-bit FIFO with head at e0; flush empties it in one cycle.
module out_fifo2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic [1:0] occ
);
    logic [3:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0] occ_q, occ_d, occ_p;
    logic       do_pop;
    always_comb begin
        do_pop = pop && occ_q != 2'd0;
        occ_p  = occ_q - {1'b0, do_pop};
        e0_d   = do_pop ? e1_q : e0_q;
        e1_d   = e1_q;
        if (push && occ_p == 2'd0) e0_d = din;
        if (push && occ_p == 2'd1) e1_d = din;
        occ_d  = flush ? 2'd0 : occ_p + {1'b0, push && occ_p != 2'd2};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end
    assign dout = e0_q;
    assign occ  = occ_q;
endmodule

// File: rtl/chip_data_seq.sv
// chip_data_seq: loads 2-bit samples into the 4-chip bit-plane store, then streams 4-bit words out
// through a credit-controlled 2-entry buffer.
module chip_data_seq
    import chip_data_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [1:0]       in_data,
    output logic             in_ready,
    output logic [WR_AW-1:0] st_wraddr,
    output logic [1:0]       st_data,
    output logic             st_wren,
    output logic             st_rden,
    output logic [RD_AW-1:0] st_rdaddr,
    input  logic [3:0]       st_q,
    output logic             out_valid,
    output logic [3:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    localparam logic [WR_AW-1:0] WR_LAST = WR_AW'(WR_TOTAL - 1);
    localparam logic [RD_AW-1:0] RD_LAST = RD_AW'(RD_TOTAL - 1);
    seq_state_t       state_q, state_d;
    logic [WR_AW-1:0] wcnt_q, wcnt_d;
    logic [RD_AW-1:0] rcnt_q, rcnt_d;
    logic             inflight_q, inflight_d, in_ready_q, in_ready_d, busy_q, busy_d;
    logic [1:0]       occ;
    logic             pop;
    // A same-cycle pop frees a slot, which is what sustains one word per clock.
    always_comb begin
        pop        = out_valid && out_ready;
        st_wren    = state_q == LOAD && in_valid && !abort;
        st_rden    = state_q == READ && !abort &&
                     ({1'b0, occ} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
        done       = state_q == DRAIN && !abort && !inflight_q && occ == 2'd1 && pop;
        inflight_d = st_rden;
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        if (abort) begin
            state_d = IDLE;
            wcnt_d  = '0;
            rcnt_d  = '0;
        end else if (state_q == IDLE && start) begin
            state_d = LOAD;
            wcnt_d  = '0;
        end else if (st_wren) begin
            wcnt_d  = wcnt_q == WR_LAST ? wcnt_q : wcnt_q + WR_AW'(1);
            state_d = wcnt_q == WR_LAST ? READ : LOAD;
            rcnt_d  = '0;
        end else if (st_rden) begin
            rcnt_d  = rcnt_q == RD_LAST ? rcnt_q : rcnt_q + RD_AW'(1);
            state_d = rcnt_q == RD_LAST ? DRAIN : READ;
        end else if (done) begin
            state_d = IDLE;
        end
        in_ready_d = state_d == LOAD;
        busy_d     = state_d != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            inflight_q <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            inflight_q <= inflight_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end
    out_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (inflight_q),
        .pop   (pop),
        .din   (st_q),
        .dout  (out_data),
        .occ   (occ)
    );
    assign out_valid = occ != 2'd0;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign st_wraddr = wcnt_q;
    assign st_rdaddr = rcnt_q;
    assign st_data   = in_data;
endmodule

// File: tb/tb_chip_data_seq.sv
// tb_chip_data_seq: directed vectors for IDLE/LOAD control plus full-frame sequences against a store model.
module tb_chip_data_seq;
    import chip_data_pkg::*;
    logic             clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]       in_data = 2'd0;
    logic [3:0]       st_q;
    logic             in_ready, st_wren, st_rden, out_valid, busy, done;
    logic [WR_AW-1:0] st_wraddr;
    logic [RD_AW-1:0] st_rdaddr;
    logic [1:0]       st_data;
    logic [3:0]       out_data;
    always #5 clk = ~clk;
    chip_data_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .st_wraddr(st_wraddr), .st_data(st_data), .st_wren(st_wren),
        .st_rden(st_rden), .st_rdaddr(st_rdaddr), .st_q(st_q), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done)
    );
    int n_cmp = 0, n_err = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    int pat_sel = 0;
    function automatic logic pat(input int a);
        return pat_sel == 0 ? logic'(a % 2) : pat_sel == 1 ? logic'(a % 3 == 0) : logic'((a / 7) % 2);
    endfunction
    function automatic int waddr(input int r, input int k);
        return (r / BLK) * NCHIP * BLK + k * BLK + r % BLK;
    endfunction
    function automatic int exp_word(input int r);
        int w = 0;
        for (int k = 0; k < NCHIP; k++) w |= int'(pat(waddr(r, k))) << k;
        return w;
    endfunction
    // Store model: write on the edge, read data one cycle after rden.
    logic mem [0:WR_TOTAL-1];
    always @(posedge clk) begin
        if (st_wren && int'(st_wraddr) < WR_TOTAL) mem[st_wraddr] <= st_data[0];
        if (st_rden) for (int k = 0; k < NCHIP; k++) st_q[k] <= mem[waddr(int'(st_rdaddr), k)];
    end
    int frame_id = 0, mon_frame = -1, exp_wa, exp_ra, exp_rd, n_done, max_out;
    bit mon_en = 0;
    always @(negedge clk) if (mon_en && !rst) begin
        if (mon_frame != frame_id) begin
            mon_frame = frame_id; exp_wa = 0; exp_ra = 0; exp_rd = 0; n_done = 0; max_out = 0;
        end
        if (st_wren) begin
            chk("wraddr", int'(st_wraddr), exp_wa);
            chk("wren_handshake", int'(in_valid && in_ready), 1);
            exp_wa++;
        end
        if (st_rden) begin
            chk("rdaddr", int'(st_rdaddr), exp_rd);
            exp_rd++;
        end
        if (out_valid && out_ready) begin
            chk("out_data", int'(out_data), exp_word(exp_ra));
            exp_ra++;
        end
        if (done) n_done++;
        if (exp_rd - exp_ra > max_out) max_out = exp_rd - exp_ra;
    end
    task automatic run_frame(input int sel, input bit tog, input bit stall, input int ab_w, input int ab_r,
                             input bit poke, input bit use_rst,
                             output int load_cyc, output int lat, output int stall_rd);
        int nacc = 0, pops = 0, read_entry = -1, first_v = -1, stall_left = -1, ab_st = 0, ra_s, cyc;
        bit hs, pp, got_done = 0, finished = 0;
        load_cyc = 0; stall_rd = 0;
        pat_sel = sel; frame_id++; mon_en = 1;
        @(posedge clk); #1; start = 1; in_valid = 0; out_ready = 1;
        @(posedge clk); #1; start = 0; in_valid = 1; in_data = {1'b0, pat(0)};
        for (cyc = 0; cyc < 6000 && !finished; cyc++) begin
            @(negedge clk);
            if (in_ready) load_cyc++;
            if (read_entry < 0 && busy && !in_ready) read_entry = cyc;
            if (first_v < 0 && out_valid) first_v = cyc;
            if (stall_left > 0 && st_rden) stall_rd++;
            hs = in_valid && in_ready; pp = out_valid && out_ready; ra_s = int'(st_rdaddr);
            if (done) got_done = 1;
            if (ab_st == 2) begin
                chk("abort_busy", int'(busy), 0);
                chk("abort_out_valid", int'(out_valid), 0);
                chk("abort_in_ready", int'(in_ready), 0);
                finished = 1;
            end else if (ab_st == 1) begin
                chk("abort_cycle_wren", int'(st_wren), 0);
                chk("abort_cycle_rden", int'(st_rden), 0);
                ab_st = 2;
            end
            if (!busy && got_done) finished = 1;
            if (!finished) begin
                @(posedge clk); #1;
                if (hs) nacc++;
                if (pp) pops++;
                abort = 0; start = 0;
                in_valid = tog ? !in_valid : 1'b1;
                in_data = {1'b0, pat(nacc)};
                if (stall_left > 0) stall_left--;
                if (stall && pops == 1 && stall_left < 0) stall_left = 10;
                out_ready = !(stall_left > 0);
                if (poke && (nacc == 100 || pops == 30)) start = 1;
                if (ab_st == 0 && ((ab_w >= 0 && nacc == ab_w && in_ready) ||
                                   (ab_r >= 0 && read_entry >= 0 && ra_s >= ab_r))) begin
                    if (use_rst) begin
                        rst = 1; #1;
                        chk("rst_busy", int'(busy), 0);
                        chk("rst_in_ready", int'(in_ready), 0);
                        chk("rst_wren", int'(st_wren), 0);
                        chk("rst_rden", int'(st_rden), 0);
                        chk("rst_out_valid", int'(out_valid), 0);
                        chk("rst_done", int'(done), 0);
                        chk("rst_wraddr", int'(st_wraddr), 0);
                        chk("rst_rdaddr", int'(st_rdaddr), 0);
                        chk("rst_out_data", int'(out_data), 0);
                        @(posedge clk); #1; rst = 0;
                        finished = 1;
                    end else begin
                        abort = 1; ab_st = 1;
                    end
                end
            end
        end
        if (!finished) chk("frame_timeout", 0, 1);
        abort = 0; start = 0; in_valid = 0; out_ready = 1;
        lat = first_v - read_entry;
    endtask
    task automatic check_full(input string nm);
        chk({nm, "_writes"}, exp_wa, WR_TOTAL);
        chk({nm, "_reads"}, exp_rd, RD_TOTAL);
        chk({nm, "_words"}, exp_ra, RD_TOTAL);
        chk({nm, "_done_pulses"}, n_done, 1);
        chk({nm, "_busy_end"}, int'(busy), 0);
    endtask
    typedef struct {logic s; logic a; logic v; logic rdy; logic bsy; logic wren; int wa;} vec_t;
    vec_t vt [14];
    int lc, lt, sr;
    initial begin
        vt[0]  = '{0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 1, 1, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 1, 0, 0, 0, 0};
        vt[3]  = '{1, 0, 1, 0, 0, 0, 0};
        vt[4]  = '{0, 0, 1, 1, 1, 1, 0};
        vt[5]  = '{0, 0, 0, 1, 1, 0, 1};
        vt[6]  = '{1, 0, 1, 1, 1, 1, 1};
        vt[7]  = '{0, 0, 1, 1, 1, 1, 2};
        vt[8]  = '{0, 1, 1, 1, 1, 0, 3};
        vt[9]  = '{0, 0, 1, 0, 0, 0, 0};
        vt[10] = '{1, 0, 0, 0, 0, 0, 0};
        vt[11] = '{0, 0, 1, 1, 1, 1, 0};
        vt[12] = '{0, 1, 0, 1, 1, 0, 1};
        vt[13] = '{0, 0, 0, 0, 0, 0, 0};
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_wraddr", int'(st_wraddr), 0);
        chk("reset_out_data", int'(out_data), 0);
        repeat (2) @(posedge clk);
        #1; rst = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            start = vt[i].s; abort = vt[i].a; in_valid = vt[i].v;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vt[i].rdy));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].bsy));
            chk($sformatf("vec%0d_wren", i), int'(st_wren), int'(vt[i].wren));
            chk($sformatf("vec%0d_wraddr", i), int'(st_wraddr), vt[i].wa);
        end
        @(posedge clk); #1; start = 0; abort = 0; in_valid = 0;
        run_frame(0, 0, 0, -1, -1, 0, 0, lc, lt, sr);
        check_full("full");
        chk("full_load_cycles", lc, WR_TOTAL);
        chk("full_first_word_latency", lt, 2);
        run_frame(1, 1, 0, -1, -1, 0, 0, lc, lt, sr);
        check_full("toggle");
        chk("toggle_load_cycles", lc, 2 * WR_TOTAL - 1);
        run_frame(2, 0, 1, -1, -1, 0, 0, lc, lt, sr);
        check_full("stall");
        chk("stall_rden", sr, 0);
        chk("stall_outstanding_le2", int'(max_out <= 2), 1);
        run_frame(0, 0, 0, 350, -1, 0, 0, lc, lt, sr);
        chk("abort_load_writes", exp_wa, 350);
        run_frame(1, 0, 0, -1, 50, 0, 0, lc, lt, sr);
        chk("abort_read_before_end", int'(exp_ra < RD_TOTAL), 1);
        run_frame(0, 0, 0, -1, -1, 0, 0, lc, lt, sr);
        check_full("after_abort");
        run_frame(2, 0, 0, -1, -1, 1, 0, lc, lt, sr);
        check_full("start_poke");
        @(posedge clk); #1; start = 1; abort = 1;
        @(posedge clk); #1; start = 0; abort = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("start_abort_idle", int'(busy), 0);
        end
        run_frame(1, 0, 0, -1, 20, 0, 1, lc, lt, sr);
        run_frame(2, 0, 0, -1, -1, 0, 0, lc, lt, sr);
        check_full("after_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
